// File: rtl/mem_port_sched.sv
// Shares one single-port memory between fetch (I) and memory stage (D).
// One transaction in flight; D has priority, bounded by a fetch-starvation streak.
module mem_port_sched #(
   parameter int XLEN         = 32,
   parameter int ADDR_W       = 32,
   parameter int MAX_D_STREAK = 4,
   parameter int TIMEOUT      = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [XLEN-1:0]   i_rdata,
   output logic              i_stall,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [XLEN-1:0]   d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [XLEN-1:0]   d_rdata,
   output logic              d_stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic [XLEN-1:0]   mem_rdata,
   input  logic              mem_rvalid,
   output logic              err
);

   localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0] LP_WD_LAST = WD_W'(TIMEOUT - 1);
   localparam logic [3:0]      LP_MAXS    = 4'(MAX_D_STREAK);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [3:0]        r_streak;
   logic [WD_W-1:0]   r_wdog;
   logic              r_owner_d;
   logic [ADDR_W-1:0] r_addr;
   logic              r_we;
   logic [XLEN-1:0]   r_wdata;

   logic w_d_win;
   logic w_i_win;
   logic w_grant;
   logic w_done;
   logic w_abort;
   logic w_run;

   // D is older in the pipe, so it wins unless fetch has waited out its streak
   assign w_d_win = d_req & ~(i_req & (r_streak == LP_MAXS));
   assign w_i_win = i_req & ~w_d_win;
   assign w_run   = ~reset;

   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_done      = 1'b0;
      w_abort     = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_d_win | w_i_win) begin
               w_grant     = 1'b1;
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (mem_rvalid) begin
               w_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (r_wdog == LP_WD_LAST) begin
               w_done      = 1'b1;
               w_abort     = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_streak  <= '0;
         r_wdog    <= '0;
         r_owner_d <= 1'b1;
         r_addr    <= '0;
         r_we      <= 1'b0;
         r_wdata   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant) begin
            r_owner_d <= w_d_win;
            r_addr    <= w_d_win ? d_addr : i_addr;
            r_we      <= w_d_win & d_we;
            r_wdata   <= w_d_win ? d_wdata : '0;
            if (w_d_win && i_req) begin
               r_streak <= r_streak + 4'd1;
            end else begin
               r_streak <= '0;
            end
         end
         if (r_state == S_ISSUE) begin
            r_wdog <= '0;
         end else if (r_state == S_WAIT && !w_done) begin
            r_wdog <= r_wdog + 1'b1;
         end
      end
   end

   assign i_gnt     = w_run & w_grant & w_i_win;
   assign d_gnt     = w_run & w_grant & w_d_win;
   assign i_rvalid  = w_done & ~r_owner_d;
   assign d_rvalid  = w_done & r_owner_d;
   assign i_rdata   = (i_rvalid & ~w_abort) ? mem_rdata : '0;
   assign d_rdata   = (d_rvalid & ~w_abort) ? mem_rdata : '0;
   assign err       = w_abort;
   assign i_stall   = w_run & i_req & ~i_rvalid;
   assign d_stall   = w_run & d_req & ~d_rvalid;
   assign mem_req   = (r_state == S_ISSUE);
   assign mem_we    = r_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_port_sched.sv
// Bench for mem_port_sched: directed scenarios plus a randomized run
// against a transaction-level model of the arbitration rules.
module tb_mem_port_sched;

   localparam int XLEN = 32;
   localparam int AW   = 32;
   localparam int MAXS = 4;
   localparam int TO   = 8;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            i_req = 1'b0;
   logic [AW-1:0]   i_addr = '0;
   logic            i_gnt, i_rvalid, i_stall;
   logic [XLEN-1:0] i_rdata;
   logic            d_req = 1'b0;
   logic            d_we = 1'b0;
   logic [AW-1:0]   d_addr = '0;
   logic [XLEN-1:0] d_wdata = '0;
   logic            d_gnt, d_rvalid, d_stall;
   logic [XLEN-1:0] d_rdata;
   logic            mem_req, mem_we;
   logic [AW-1:0]   mem_addr;
   logic [XLEN-1:0] mem_wdata;
   logic [XLEN-1:0] mem_rdata = '0;
   logic            mem_rvalid = 1'b0;
   logic            err;

   int checks = 0;
   int errors = 0;

   logic [31:0]     mem [256];
   int              m_cnt = -1;
   int              m_lat = 1;
   logic            m_we = 1'b0;
   logic [AW-1:0]   m_addr = '0;
   logic [XLEN-1:0] m_wdata = '0;

   wire [7:0] obs = {i_gnt, d_gnt, mem_req, i_rvalid,
                     d_rvalid, i_stall, d_stall, err};

   mem_port_sched #(
      .XLEN(XLEN), .ADDR_W(AW), .MAX_D_STREAK(MAXS), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
      .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_stall(i_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .d_stall(d_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_rvalid(mem_rvalid), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] raddr();
      logic [7:0] w;
      w = 8'($urandom);
      return {22'b0, w, 2'b00};
   endfunction

   // memory side of the cycle: deliver a pending response, then settle
   task automatic settle();
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (m_cnt > 0) begin
         m_cnt--;
         if (m_cnt == 0) begin
            mem_rvalid = 1'b1;
            if (m_we) mem[m_addr[9:2]] = m_wdata;
            else mem_rdata = mem[m_addr[9:2]];
            m_cnt = -1;
         end
      end
      #1;
   endtask

   task automatic tick();
      if (mem_req) begin
         m_we    = mem_we;
         m_addr  = mem_addr;
         m_wdata = mem_wdata;
         m_cnt   = (m_lat > 0) ? m_lat : -1;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; i_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
      i_addr = 32'h40; d_addr = 32'h80; d_wdata = 32'h5555;
      settle();
      checks++;
      if (obs !== 8'b0 || mem_we !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctl got %b/%b exp 0", obs, mem_we);
      end
      checks++;
      if ({mem_addr, mem_wdata, i_rdata, d_rdata} !== '0) begin
         errors++;
         $display("FAIL reset_data got %h %h exp 0", mem_addr, mem_wdata);
      end
      tick();
      tick();
      i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; reset = 1'b0;
      settle();
      checks++;
      if (obs !== 8'b0) begin
         errors++;
         $display("FAIL reset_idle got %b exp 0", obs);
      end
      tick();
   endtask

   task automatic test_single_fetch();
      logic [7:0] e;
      mem[8'h10] = 32'hDEADBEEF;
      m_lat = 2; i_req = 1'b1; i_addr = 32'h40;
      for (int k = 0; k < 4; k++) begin
         settle();
         e = {k == 0, 1'b0, k == 1, k == 3, 1'b0, k < 3, 1'b0, 1'b0};
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL fetch_ctl k=%0d got %b exp %b", k, obs, e);
         end
         if (k == 1) begin
            checks++;
            if (mem_addr !== 32'h40 || mem_we !== 1'b0) begin
               errors++;
               $display("FAIL fetch_addr got %h/%b exp 40/0", mem_addr, mem_we);
            end
         end
         if (k == 3) begin
            checks++;
            if (i_rdata !== 32'hDEADBEEF) begin
               errors++;
               $display("FAIL fetch_data got %h exp deadbeef", i_rdata);
            end
         end
         tick();
      end
      i_req = 1'b0;
   endtask

   task automatic test_simultaneous();
      logic [7:0] e;
      m_lat = 1;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
      i_req = 1'b1; i_addr = 32'h44;
      for (int k = 0; k < 6; k++) begin
         if (k == 3) d_req = 1'b0;
         settle();
         e = {k == 3, k == 0, k == 1 || k == 4, k == 5,
              k == 2, k < 5, k < 2, 1'b0};
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL simul_ctl k=%0d got %b exp %b", k, obs, e);
         end
         if (k == 2) begin
            checks++;
            if (d_rdata !== mem[8'h40]) begin
               errors++;
               $display("FAIL simul_ddata got %h exp %h", d_rdata, mem[8'h40]);
            end
         end
         if (k == 4) begin
            checks++;
            if (mem_addr !== 32'h44) begin
               errors++;
               $display("FAIL simul_iaddr got %h exp 44", mem_addr);
            end
         end
         if (k == 5) begin
            checks++;
            if (i_rdata !== mem[8'h11]) begin
               errors++;
               $display("FAIL simul_idata got %h exp %h", i_rdata, mem[8'h11]);
            end
         end
         tick();
      end
      i_req = 1'b0;
   endtask

   task automatic test_starvation();
      int  ngr;
      bit  fin;
      bit  exp_i;
      ngr = 0; fin = 0;
      i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
      for (int t = 0; t < 300 && !fin; t++) begin
         m_lat = $urandom_range(1, 3);
         settle();
         if (i_gnt || d_gnt) begin
            exp_i = (ngr % 5) == 4;
            checks++;
            if (i_gnt !== exp_i || d_gnt !== !exp_i) begin
               errors++;
               $display("FAIL starve_order n=%0d got i%b d%b exp i%b",
                        ngr, i_gnt, d_gnt, exp_i);
            end
            ngr++;
         end
         if ((i_rvalid || d_rvalid) && ngr == 10) fin = 1;
         tick();
      end
      checks++;
      if (!fin) begin
         errors++;
         $display("FAIL starve_timeout got %0d grants exp 10", ngr);
      end
      i_req = 1'b0; d_req = 1'b0;
   endtask

   task automatic test_store();
      logic [7:0] e;
      m_lat = 3;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h1234;
      for (int k = 0; k < 5; k++) begin
         settle();
         e = {1'b0, k == 0, k == 1, 1'b0, k == 4, 1'b0, k < 4, 1'b0};
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL store_ctl k=%0d got %b exp %b", k, obs, e);
         end
         if (k == 1) begin
            checks++;
            if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h20, 32'h1234}) begin
               errors++;
               $display("FAIL store_bus got %b %h %h exp 1 20 1234",
                        mem_we, mem_addr, mem_wdata);
            end
         end
         tick();
      end
      d_we = 1'b0; m_lat = 1;
      for (int k = 0; k < 3; k++) begin
         settle();
         e = {1'b0, k == 0, k == 1, 1'b0, k == 2, 1'b0, k < 2, 1'b0};
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL reload_ctl k=%0d got %b exp %b", k, obs, e);
         end
         if (k == 2) begin
            checks++;
            if (d_rdata !== 32'h1234) begin
               errors++;
               $display("FAIL reload_data got %h exp 1234", d_rdata);
            end
         end
         tick();
      end
      d_req = 1'b0;
   endtask

   task automatic test_watchdog();
      logic [7:0] e;
      m_lat = 0;
      i_req = 1'b1; i_addr = 32'h80;
      for (int k = 0; k < TO + 2; k++) begin
         settle();
         e = {k == 0, 1'b0, k == 1, k == TO + 1, 1'b0,
              k < TO + 1, 1'b0, k == TO + 1};
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL wdog_ctl k=%0d got %b exp %b", k, obs, e);
         end
         if (k == TO + 1) begin
            checks++;
            if (i_rdata !== 32'h0) begin
               errors++;
               $display("FAIL wdog_data got %h exp 0", i_rdata);
            end
         end
         tick();
      end
      i_req = 1'b0;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h84; m_lat = 1;
      for (int k = 0; k < 3; k++) begin
         settle();
         e = {1'b0, k == 0, k == 1, 1'b0, k == 2, 1'b0, k < 2, 1'b0};
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL wdog_next k=%0d got %b exp %b", k, obs, e);
         end
         tick();
      end
      d_req = 1'b0;
   endtask

   task automatic test_reset_mid_wait();
      logic [7:0] e;
      m_lat = 5;
      i_req = 1'b1; i_addr = 32'h48;
      settle();
      checks++;
      if (i_gnt !== 1'b1) begin
         errors++;
         $display("FAIL rmw_gnt got %b exp 1", i_gnt);
      end
      tick();
      settle();
      tick();
      settle();
      reset = 1'b1;
      #1;
      checks++;
      if (obs !== 8'b0 || mem_addr !== '0) begin
         errors++;
         $display("FAIL rmw_async got %b %h exp 0", obs, mem_addr);
      end
      tick();
      reset = 1'b0; i_req = 1'b0;
      for (int k = 3; k < 9; k++) begin
         settle();
         checks++;
         if (obs !== 8'b0) begin
            errors++;
            $display("FAIL rmw_late k=%0d got %b exp 0", k, obs);
         end
         tick();
      end
      m_lat = 2; i_req = 1'b1; i_addr = 32'h4C;
      for (int k = 0; k < 4; k++) begin
         settle();
         e = {k == 0, 1'b0, k == 1, k == 3, 1'b0, k < 3, 1'b0, 1'b0};
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL rmw_again k=%0d got %b exp %b", k, obs, e);
         end
         if (k == 3) begin
            checks++;
            if (i_rdata !== mem[8'h13]) begin
               errors++;
               $display("FAIL rmw_data got %h exp %h", i_rdata, mem[8'h13]);
            end
         end
         tick();
      end
      i_req = 1'b0;
   endtask

   task automatic test_random();
      bit          busy, own_d, ip, dp, dwin, iwin, irv, drv;
      int          iss, done, streak;
      logic [31:0] g_addr, g_wdata;
      logic        g_we;
      logic [7:0]  e;
      busy = 0; own_d = 0; ip = 0; dp = 0;
      iss = -1; done = -1; streak = 0;
      g_addr = '0; g_wdata = '0; g_we = 1'b0;
      for (int t = 0; t < 600; t++) begin
         if (ip || !i_req) begin
            i_req  = ip ? 1'($urandom % 2) : 1'($urandom % 3 == 0);
            i_addr = raddr();
         end
         if (dp || !d_req) begin
            d_req   = dp ? 1'($urandom % 2) : 1'($urandom % 3 == 0);
            d_we    = 1'($urandom % 2);
            d_addr  = raddr();
            d_wdata = $urandom;
         end
         settle();
         dwin = !busy && d_req && !(i_req && streak == MAXS);
         iwin = !busy && i_req && !(d_req && !(i_req && streak == MAXS));
         irv  = busy && t == done && !own_d;
         drv  = busy && t == done && own_d;
         e = {iwin, dwin, busy && t == iss, irv, drv,
              i_req && !irv, d_req && !drv, 1'b0};
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL rand_ctl t=%0d got %b exp %b", t, obs, e);
         end
         if (busy && t == iss) begin
            checks++;
            if (mem_addr !== g_addr || mem_we !== g_we ||
                (g_we && mem_wdata !== g_wdata)) begin
               errors++;
               $display("FAIL rand_bus t=%0d got %b %h %h exp %b %h %h",
                        t, mem_we, mem_addr, mem_wdata, g_we, g_addr, g_wdata);
            end
         end
         if (irv || (drv && !g_we)) begin
            checks++;
            if ((irv ? i_rdata : d_rdata) !== mem[g_addr[9:2]]) begin
               errors++;
               $display("FAIL rand_data t=%0d got %h exp %h", t,
                        irv ? i_rdata : d_rdata, mem[g_addr[9:2]]);
            end
         end
         ip = irv; dp = drv;
         if (busy && t == done) busy = 0;
         if (dwin || iwin) begin
            busy    = 1;
            own_d   = dwin;
            g_addr  = dwin ? d_addr : i_addr;
            g_we    = dwin && d_we;
            g_wdata = d_wdata;
            m_lat   = $urandom_range(1, 4);
            iss     = t + 1;
            done    = t + 1 + m_lat;
            streak  = (dwin && i_req) ? streak + 1 : 0;
         end
         tick();
      end
      i_req = 1'b0; d_req = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      @(negedge clk);
      test_reset();
      test_single_fetch();
      test_simultaneous();
      test_starvation();
      test_store();
      test_watchdog();
      test_reset_mid_wait();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got running exp finished");
      $fatal(1, "bench time limit reached");
   end

endmodule
